// File: rtl/pipe_collision_scheduler.sv
// pipe_collision_scheduler: game-state FSM with a shared bird/pipe collision and scoring datapath
//
// Scans one pipe slot per cycle after each frame tick and then decides hit or no hit.
// Optional build macro: GROUND_COLLIDE_EN (also treat the top and bottom screen edges as a hit).
//
// Ports:
//    Clk, Reset       clock; asynchronous active-high reset
//    Start            1-cycle pulse that starts or restarts the game
//    FrameTick        1-cycle pulse, once per frame
//    XBird, YBird     bird centre coordinates
//    XPipes, YPipes   per-slot pipe centre X and gap top Y; slot k at [k*COORD_W +: COORD_W]
//    Playing          high in PLAY and SCAN
//    Dead             high in DEAD
//    Collide          1-cycle pulse on entry to DEAD
//    ScanDone         1-cycle pulse at the end of every scan
//    Score            pipes passed since Start (saturating)
module pipe_collision_scheduler #(
   parameter int NUM_PIPES   = 2,
   parameter int COORD_W     = 10,
   parameter int BIRD_HALF   = 10,
   parameter int PIPE_HALF_W = 50,
   parameter int GAP_H       = 100,
   parameter int SCREEN_H    = 480,
   parameter int SCORE_W     = 8
) (
   input  logic                           Clk,
   input  logic                           Reset,
   input  logic                           Start,
   input  logic                           FrameTick,
   input  logic [COORD_W-1:0]             XBird,
   input  logic [COORD_W-1:0]             YBird,
   input  logic [NUM_PIPES*COORD_W-1:0]   XPipes,
   input  logic [NUM_PIPES*COORD_W-1:0]   YPipes,
   output logic                           Playing,
   output logic                           Dead,
   output logic                           Collide,
   output logic                           ScanDone,
   output logic [SCORE_W-1:0]             Score
);
`ifdef GROUND_COLLIDE_EN
   localparam bit GND_EN = 1'b1;
`else
   localparam bit GND_EN = 1'b0;
`endif
   localparam int XW = COORD_W + 2;
   localparam int IW = NUM_PIPES > 1 ? $clog2(NUM_PIPES) : 1;
   localparam logic [XW-1:0] BH = XW'(BIRD_HALF);
   localparam logic [XW-1:0] PW = XW'(PIPE_HALF_W);
   localparam logic [XW-1:0] GH = XW'(GAP_H);
   localparam logic [XW-1:0] SH = XW'(SCREEN_H);

   typedef enum logic [2:0] {IDLE, PLAY, SCAN, RESOLVE, DEAD} state_t;

   state_t                 state_q, state_d;
   logic [IW-1:0]          idx_q, idx_d;
   logic                   hit_q, hit_d;
   logic [COORD_W-1:0]     bx_q, bx_d, by_q, by_d;
   logic [SCORE_W-1:0]     score_q, score_d;
   logic [NUM_PIPES-1:0]   passed_q, passed_d;
   logic                   collide_q, collide_d;
   logic                   scan_done_q, scan_done_d;

   logic [XW-1:0]          bxe, bye, xp, yp;
   logic                   xoverlap, outgap, passing, respawn, ground;

   // Every term is kept on the additive side so no comparison can underflow at the screen edges.
   always_comb begin
      bxe      = XW'(bx_q);
      bye      = XW'(by_q);
      xp       = XW'(XPipes[idx_q*COORD_W +: COORD_W]);
      yp       = XW'(YPipes[idx_q*COORD_W +: COORD_W]);
      xoverlap = (bxe + BH + PW > xp) && (xp + PW + BH > bxe);
      outgap   = (bye < yp + BH) || (bye + BH > yp + GH);
      passing  = xp + PW + BH < bxe;
      respawn  = xp > bxe + BH + PW;
      ground   = GND_EN && ((bye + BH >= SH) || (bye < BH));
   end

   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      hit_d       = hit_q;
      bx_d        = bx_q;
      by_d        = by_q;
      score_d     = score_q;
      passed_d    = passed_q;
      collide_d   = 1'b0;
      scan_done_d = 1'b0;
      case (state_q)
         IDLE, DEAD: begin
            if (Start) begin
               state_d  = PLAY;
               score_d  = '0;
               passed_d = '0;
            end
         end
         PLAY: begin
            if (FrameTick) begin
               state_d = SCAN;
               bx_d    = XBird;
               by_d    = YBird;
               idx_d   = '0;
               hit_d   = 1'b0;
            end
         end
         SCAN: begin
            hit_d = hit_q | (xoverlap & outgap);
            if (passing && !passed_q[idx_q]) begin
               passed_d[idx_q] = 1'b1;
               score_d         = score_q + SCORE_W'(score_q != '1);
            end else if (respawn) begin
               passed_d[idx_q] = 1'b0;
            end
            idx_d = idx_q + 1'b1;
            if (idx_q == IW'(NUM_PIPES - 1)) begin
               state_d = RESOLVE;
               idx_d   = '0;
            end
         end
         RESOLVE: begin
            scan_done_d = 1'b1;
            state_d     = (hit_q || ground) ? DEAD : PLAY;
            collide_d   = hit_q || ground;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         state_q     <= IDLE;
         idx_q       <= '0;
         hit_q       <= 1'b0;
         bx_q        <= '0;
         by_q        <= '0;
         score_q     <= '0;
         passed_q    <= '0;
         collide_q   <= 1'b0;
         scan_done_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         hit_q       <= hit_d;
         bx_q        <= bx_d;
         by_q        <= by_d;
         score_q     <= score_d;
         passed_q    <= passed_d;
         collide_q   <= collide_d;
         scan_done_q <= scan_done_d;
      end
   end

   assign Playing  = (state_q == PLAY) || (state_q == SCAN);
   assign Dead     = state_q == DEAD;
   assign Collide  = collide_q;
   assign ScanDone = scan_done_q;
   assign Score    = score_q;
endmodule

// File: tb/tb_pipe_collision_scheduler.sv
// tb_pipe_collision_scheduler: directed self-checking bench for pipe_collision_scheduler
module tb_pipe_collision_scheduler;
`ifdef GROUND_COLLIDE_EN
   localparam bit GND_EN = 1'b1;
`else
   localparam bit GND_EN = 1'b0;
`endif
   logic        Clk = 1'b0;
   logic        Reset = 1'b1;
   logic        Start = 1'b0;
   logic        FrameTick = 1'b0;
   logic [9:0]  XBird = '0;
   logic [9:0]  YBird = '0;
   logic [19:0] XPipes = '0;
   logic [19:0] YPipes = '0;
   logic        Playing, Dead, Collide, ScanDone;
   logic [7:0]  Score;
   int n_vec = 0;
   int n_err = 0;

   pipe_collision_scheduler dut (
      .Clk(Clk), .Reset(Reset), .Start(Start), .FrameTick(FrameTick),
      .XBird(XBird), .YBird(YBird), .XPipes(XPipes), .YPipes(YPipes),
      .Playing(Playing), .Dead(Dead), .Collide(Collide), .ScanDone(ScanDone), .Score(Score)
   );

   always #5 Clk = ~Clk;

   task automatic set_scene(input int bx, input int by, input int x0, input int y0, input int x1, input int y1);
      XBird  = 10'(bx);
      YBird  = 10'(by);
      XPipes = {10'(x1), 10'(x0)};
      YPipes = {10'(y1), 10'(y0)};
   endtask

   task automatic pulse_start;
      @(negedge Clk) Start = 1'b1;
      @(negedge Clk) Start = 1'b0;
   endtask

   // Pulses FrameTick and samples ScanDone 2 and 3 cycles after the sampling edge.
   task automatic run_frame(output logic sd_early, output logic sd, output logic col);
      @(negedge Clk) FrameTick = 1'b1;
      @(negedge Clk) FrameTick = 1'b0;
      @(posedge Clk);
      @(posedge Clk);
      #1 sd_early = ScanDone;
      @(posedge Clk);
      #1 sd = ScanDone;
      col = Collide;
   endtask

   task automatic test_reset;
      @(negedge Clk) Reset = 1'b0;
      n_vec++;
      if ({Playing, Dead, Collide, ScanDone, Score} !== 12'h0) begin
         n_err++;
         $display("FAIL reset_init: got %b %b %b %b %0d, want 0 0 0 0 0", Playing, Dead, Collide, ScanDone, Score);
      end
      pulse_start;
      set_scene(100, 200, 30, 180, 600, 0);
      @(negedge Clk) FrameTick = 1'b1;
      @(negedge Clk) FrameTick = 1'b0;
      @(posedge Clk);
      #1;
      n_vec++;
      if (Score !== 8'd1 || Playing !== 1'b1) begin
         n_err++;
         $display("FAIL pre_reset_score: got score %0d playing %b, want 1 1", Score, Playing);
      end
      #2 Reset = 1'b1;
      #1;
      n_vec++;
      if ({Playing, Dead, Collide, ScanDone, Score} !== 12'h0) begin
         n_err++;
         $display("FAIL reset_mid_scan: got %b %b %b %b %0d, want 0 0 0 0 0", Playing, Dead, Collide, ScanDone, Score);
      end
      @(negedge Clk) Reset = 1'b0;
   endtask

   task automatic test_idle_tick;
      logic seen;
      seen = 1'b0;
      @(negedge Clk) FrameTick = 1'b1;
      @(negedge Clk) FrameTick = 1'b0;
      repeat (4) begin
         @(posedge Clk);
         #1 seen |= ScanDone | Playing;
      end
      n_vec++;
      if (seen !== 1'b0) begin
         n_err++;
         $display("FAIL idle_tick: got scan/playing %b, want 0", seen);
      end
   endtask

   task automatic test_no_hit;
      logic e, s, c;
      pulse_start;
      set_scene(100, 200, 120, 180, 600, 0);
      run_frame(e, s, c);
      n_vec++;
      if ({e, s, c} !== 3'b010) begin
         n_err++;
         $display("FAIL no_hit_timing: got early %b done %b collide %b, want 0 1 0", e, s, c);
      end
      n_vec++;
      if (Playing !== 1'b1 || Dead !== 1'b0) begin
         n_err++;
         $display("FAIL no_hit_state: got playing %b dead %b, want 1 0", Playing, Dead);
      end
      @(posedge Clk);
      #1;
      n_vec++;
      if (ScanDone !== 1'b0) begin
         n_err++;
         $display("FAIL scandone_pulse: got %b, want 0", ScanDone);
      end
   endtask

   task automatic test_hit;
      logic e, s, c;
      set_scene(100, 200, 120, 195, 600, 0);
      run_frame(e, s, c);
      n_vec++;
      if ({e, s, c, Dead} !== 4'b0111) begin
         n_err++;
         $display("FAIL hit: got early %b done %b collide %b dead %b, want 0 1 1 1", e, s, c, Dead);
      end
      run_frame(e, s, c);
      n_vec++;
      if ({e, s, c, Dead, Playing} !== 5'b00010) begin
         n_err++;
         $display("FAIL dead_tick: got %b %b %b dead %b playing %b, want 0 0 0 1 0", e, s, c, Dead, Playing);
      end
      pulse_start;
      n_vec++;
      if (Playing !== 1'b1 || Dead !== 1'b0 || Score !== 8'd0) begin
         n_err++;
         $display("FAIL restart: got playing %b dead %b score %0d, want 1 0 0", Playing, Dead, Score);
      end
   endtask

   task automatic test_score;
      logic e, s, c;
      set_scene(100, 200, 30, 180, 600, 0);
      run_frame(e, s, c);
      n_vec++;
      if (Score !== 8'd1) begin
         n_err++;
         $display("FAIL score_pass: got %0d, want 1", Score);
      end
      run_frame(e, s, c);
      n_vec++;
      if (Score !== 8'd1) begin
         n_err++;
         $display("FAIL score_no_double: got %0d, want 1", Score);
      end
      set_scene(100, 200, 600, 180, 600, 0);
      run_frame(e, s, c);
      n_vec++;
      if (Score !== 8'd1) begin
         n_err++;
         $display("FAIL score_respawn: got %0d, want 1", Score);
      end
      set_scene(100, 200, 30, 180, 600, 0);
      run_frame(e, s, c);
      n_vec++;
      if (Score !== 8'd2 || Playing !== 1'b1) begin
         n_err++;
         $display("FAIL score_repass: got %0d playing %b, want 2 1", Score, Playing);
      end
      for (int i = 0; i < 126; i++) begin
         set_scene(100, 200, 600, 180, 600, 0);
         run_frame(e, s, c);
         set_scene(100, 200, 30, 180, 30, 0);
         run_frame(e, s, c);
      end
      n_vec++;
      if (Score !== 8'd254) begin
         n_err++;
         $display("FAIL score_254: got %0d, want 254", Score);
      end
      for (int i = 0; i < 2; i++) begin
         set_scene(100, 200, 600, 180, 600, 0);
         run_frame(e, s, c);
         set_scene(100, 200, 30, 180, 30, 0);
         run_frame(e, s, c);
         n_vec++;
         if (Score !== 8'd255) begin
            n_err++;
            $display("FAIL score_saturate%0d: got %0d, want 255", i, Score);
         end
      end
   endtask

   task automatic test_start_in_scan;
      @(negedge Clk) FrameTick = 1'b1;
      @(negedge Clk) begin
         FrameTick = 1'b0;
         Start = 1'b1;
      end
      @(negedge Clk) Start = 1'b0;
      @(posedge Clk);
      @(posedge Clk);
      #1;
      n_vec++;
      if (ScanDone !== 1'b1 || Score !== 8'd255 || Playing !== 1'b1) begin
         n_err++;
         $display("FAIL start_in_scan: got done %b score %0d playing %b, want 1 255 1", ScanDone, Score, Playing);
      end
   endtask

   task automatic test_ground;
      logic e, s, c;
      pulse_start;
      set_scene(100, 475, 600, 180, 600, 0);
      run_frame(e, s, c);
      n_vec++;
      if (s !== 1'b1 || c !== GND_EN || Dead !== GND_EN || Playing !== !GND_EN) begin
         n_err++;
         $display("FAIL ground: got done %b collide %b dead %b playing %b, want 1 %b %b %b",
                  s, c, Dead, Playing, GND_EN, GND_EN, !GND_EN);
      end
   endtask

   initial begin
      test_reset;
      test_idle_tick;
      test_no_hit;
      test_hit;
      test_score;
      test_start_in_scan;
      test_ground;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule

// File: doc/pipe_collision_scheduler.md
Name: pipe_collision_scheduler

Overview:
Game-state controller that owns the bird/pipe collision check and shares one comparator datapath across all on-screen pipes. On each frame tick in PLAY it scans the pipes one per cycle, then makes a hit/no-hit decision. It sets the game state (IDLE/PLAY/DEAD) and maintains the score counter. It sits between the pipe generator / bird physics blocks and the VGA renderer / score display.

Parameters:
NUM_PIPES, 2, number of pipe slots scanned per frame (1..8)
COORD_W, 10, width of every X/Y coordinate
BIRD_HALF, 10, bird bounding-box half-size (X and Y)
PIPE_HALF_W, 50, pipe half-width in X
GAP_H, 100, vertical gap height; the gap spans YPipe .. YPipe+GAP_H
SCREEN_H, 480, visible screen height in pixels
SCORE_W, 8, score counter width

Ports:
Clk  input  1  system clock
Reset  input  1  asynchronous, active-high reset
Start  input  1  1-cycle pulse; starts or restarts the game
FrameTick  input  1  1-cycle pulse, once per frame (start of vblank)
XBird  input  COORD_W  bird centre X
YBird  input  COORD_W  bird centre Y
XPipes  input  NUM_PIPES*COORD_W  pipe centre X; slot k at bits [k*COORD_W +: COORD_W]
YPipes  input  NUM_PIPES*COORD_W  top of gap per slot, same packing
Playing  output  1  high in PLAY and SCAN
Dead  output  1  high in DEAD
Collide  output  1  1-cycle pulse on the transition into DEAD
ScanDone  output  1  1-cycle pulse at the end of every scan
Score  output  SCORE_W  pipes passed since Start

Behaviour:
- Reset (async): state IDLE; all outputs 0; Score=0; passed[] flags=0; scan index=0; hit accumulator=0.
- States: IDLE, PLAY, SCAN, RESOLVE, DEAD.
- IDLE: Start -> PLAY with Score=0 and passed[]=0. FrameTick is ignored.
- PLAY: FrameTick -> SCAN. XBird/YBird are latched on that edge, index=0, hit=0.
- SCAN: evaluates slot=index in one cycle, then index++. After slot NUM_PIPES-1 the next state is RESOLVE. Pipe buses are read live; the pipe generator holds them stable from FrameTick until ScanDone.
- RESOLVE: ScanDone=1. If hit (or ground hit, see Optional Feature) -> DEAD and Collide=1 in the same cycle. Otherwise -> PLAY.
- Scan latency: ScanDone is high NUM_PIPES+1 cycles after the FrameTick edge.
- DEAD: holds Score. Start -> PLAY with Score=0 and passed[]=0.
- Start and FrameTick during SCAN or RESOLVE are ignored.
- Arithmetic: all comparisons are zero-extended to COORD_W+2 bits. Terms are rearranged so nothing is subtracted, so there is no underflow at screen edges. Bx/By below are the latched bird coordinates, Xp/Yp the current slot.
  - xoverlap = (Bx+BIRD_HALF+PIPE_HALF_W > Xp) AND (Xp+PIPE_HALF_W+BIRD_HALF > Bx)
  - outgap = (By < Yp+BIRD_HALF) OR (By+BIRD_HALF > Yp+GAP_H)
  - hit |= xoverlap AND outgap
- Score per slot (evaluated in the same SCAN cycle):
  - If Xp+PIPE_HALF_W+BIRD_HALF < Bx and passed[k]=0: set passed[k] and Score++ (saturating at all-ones).
  - If Xp > Bx+BIRD_HALF+PIPE_HALF_W (pipe respawned to the right): clear passed[k].
- Score updates even on a scan that ends in a hit.

Optional Feature:
GROUND_COLLIDE_EN
- Defined: RESOLVE also treats By+BIRD_HALF >= SCREEN_H or By < BIRD_HALF as a hit.
- Undefined: only pipe hits end the game; the bird position is unconstrained.

Test Plan:
All scenarios use default parameters.
- Reset asserted mid-SCAN -> state IDLE immediately; Playing, Dead, Collide, ScanDone=0; Score=0.
- Start; FrameTick with bird(100,200), pipe0(120,180), pipe1(600,0) -> ScanDone exactly 3 cycles after the tick; Collide=0; Playing=1.
- Same as above but pipe0 Y=195 -> ScanDone and Collide both pulse 3 cycles after the tick; Dead=1; further FrameTicks are ignored; Start returns to PLAY with Score=0.
- Pipe0 X=30 with bird X=100, ticked twice -> Score=1 after both scans. Then pipe0 X=600 for one tick, then X=30 again -> Score=2. Also preload Score=255 and check it stays at 255.
- Bird(100,475), pipes at X=600 -> with GROUND_COLLIDE_EN: Collide pulses and Dead=1. Without it: no hit and state stays PLAY.
- FrameTick in IDLE -> no ScanDone. Start pulsed during SCAN -> Score is not cleared and the scan completes normally.
